ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of the RAM address.
REQ-002 SHALL have parameter MEM_WIDTH, default 16, width of the RAM data word.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports Req0/Req1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports We0/We1  input  1  1 = write, 0 = read, for requester 0/1.
REQ-007 SHALL have ports Addr0/Addr1  input  ADDR_WIDTH  access address for requester 0/1.
REQ-008 SHALL have ports WData0/WData1  input  MEM_WIDTH  write data for requester 0/1.
REQ-009 SHALL have ports Gnt0/Gnt1  output  1  one-cycle grant pulse to requester 0/1.
REQ-010 SHALL have ports RValid0/RValid1  output  1  one-cycle read-data-valid pulse to requester 0/1.
REQ-011 SHALL have port RData  output  MEM_WIDTH  read data shared by both requesters, qualified by RValid0/RValid1.
REQ-012 SHALL have ports RamWrEn, RamRdEn  output  1  RAM write and read enables.
REQ-013 SHALL have ports RamAddress  output  ADDR_WIDTH  and RamWrData  output  MEM_WIDTH  to the RAM.
REQ-014 SHALL have port RamRdData  input  MEM_WIDTH  RAM read data, valid one cycle after the RdEn cycle.
REQ-015 SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RDWAIT; all outputs SHALL be registered.
REQ-017 In IDLE with any ReqN high, SHALL select one requester, latch its We/Addr/WData, and enter ACCESS.
REQ-018 In ACCESS, SHALL assert the selected GntN, drive RamAddress and RamWrData, and assert RamWrEn (We=1) or RamRdEn (We=0) for exactly one cycle.
REQ-019 From ACCESS, a write SHALL return to IDLE and a read SHALL enter RDWAIT.
REQ-020 In RDWAIT, SHALL capture RamRdData into RData and return to IDLE, with RValidN pulsed high in the following cycle.
REQ-021 Latency SHALL be: request sampled in cycle T, Gnt and RAM enable in T+1, and (reads only) RValid in T+3.
REQ-022 Throughput SHALL be one write per 2 cycles or one read per 3 cycles; a request seen in the same cycle as RValid SHALL be accepted.
REQ-023 A requester SHALL hold ReqN, WeN, AddrN and WDataN stable until GntN; the arbiter ignores changes after the latch cycle.
REQ-024 RamWrEn and RamRdEn SHALL never be high together, and never high outside ACCESS.
REQ-025 Gnt0 and Gnt1 SHALL never be high together; likewise RValid0 and RValid1.
REQ-026 RData SHALL hold its last value until the next read capture.

Reset
REQ-027 When Rst is high at a clock edge: FSM to IDLE; all Gnt, RValid, RamWrEn, RamRdEn and Busy to 0; RamAddress, RamWrData and RData to 0; last-grant pointer to 1.
REQ-028 Rst asserted in ACCESS or RDWAIT SHALL abort the access with no RValid pulse and no further RAM enable.

Configuration
REQ-029 With macro RAM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not granted last, and the pointer updates on every grant.
REQ-030 Without RAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests, and the pointer logic SHALL be absent.

Verification
REQ-031 Reset: Rst=1 for 2 cycles with Req0=1 -> all outputs 0, Busy=0, no RAM enable.
REQ-032 Single write then read: Req0, We0=1, Addr0=2, WData0=10 -> Gnt0 and RamWrEn one cycle with RamAddress=2, RamWrData=10. Req0, We0=0, Addr0=2 -> RValid0 at T+3 with RData=10.
REQ-033 Contention with macro: Req0 and Req1 held as writes to addr 3 and 4 -> grants alternate Gnt0, Gnt1, Gnt0, ... every 2 cycles. Without macro -> Gnt0 only while Req0 is held.
REQ-034 Cross-requester read: requester 1 writes 25 to addr 3, then requester 0 reads addr 3 -> RValid0=1, RValid1=0, RData=25.
REQ-035 Reset mid-read: Rst=1 in the RDWAIT cycle -> no RValid, FSM in IDLE, and a fresh Req1 read is served normally afterwards.
REQ-036 An assertion monitor throughout all scenarios SHALL check REQ-024 and REQ-025.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester single-port RAM arbiter, IDLE/ACCESS/RDWAIT FSM with registered outputs.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int MEM_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Req0,
   input  logic                  Req1,
   input  logic                  We0,
   input  logic                  We1,
   input  logic [ADDR_WIDTH-1:0] Addr0,
   input  logic [ADDR_WIDTH-1:0] Addr1,
   input  logic [MEM_WIDTH-1:0]  WData0,
   input  logic [MEM_WIDTH-1:0]  WData1,
   output logic                  Gnt0,
   output logic                  Gnt1,
   output logic                  RValid0,
   output logic                  RValid1,
   output logic [MEM_WIDTH-1:0]  RData,
   output logic                  RamWrEn,
   output logic                  RamRdEn,
   output logic [ADDR_WIDTH-1:0] RamAddress,
   output logic [MEM_WIDTH-1:0]  RamWrData,
   input  logic [MEM_WIDTH-1:0]  RamRdData,
   output logic                  Busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
   state_t                state_q, state_d;
   logic                  sel_q, sel_d, we_q, we_d, pick1;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                  ram_wr_en_q, ram_wr_en_d, ram_rd_en_q, ram_rd_en_d, busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [MEM_WIDTH-1:0]  ram_wdata_q, ram_wdata_d, rdata_q, rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic                  last_q, last_d;
`endif
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      we_d        = we_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      ram_wr_en_d = 1'b0;
      ram_rd_en_d = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rdata_d     = rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
      // On contention, requester 1 wins only if requester 0 was granted last
      pick1       = Req1 & (~Req0 | ~last_q);
`else
      pick1       = Req1 & ~Req0;
`endif
      case (state_q)
         IDLE: if (Req0 | Req1) begin
            state_d     = ACCESS;
            sel_d       = pick1;
            we_d        = pick1 ? We1 : We0;
            gnt0_d      = ~pick1;
            gnt1_d      = pick1;
            ram_wr_en_d = we_d;
            ram_rd_en_d = ~we_d;
            ram_addr_d  = pick1 ? Addr1 : Addr0;
            ram_wdata_d = pick1 ? WData1 : WData0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_d      = pick1;
`endif
         end
         ACCESS: state_d = we_q ? IDLE : RDWAIT;
         RDWAIT: begin
            state_d   = IDLE;
            rdata_d   = RamRdData;
            rvalid0_d = ~sel_q;
            rvalid1_d = sel_q;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         we_q        <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         ram_wr_en_q <= 1'b0;
         ram_rd_en_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         ram_wr_en_q <= ram_wr_en_d;
         ram_rd_en_q <= ram_rd_en_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end
   assign Gnt0       = gnt0_q;
   assign Gnt1       = gnt1_q;
   assign RValid0    = rvalid0_q;
   assign RValid1    = rvalid1_q;
   assign RData      = rdata_q;
   assign RamWrEn    = ram_wr_en_q;
   assign RamRdEn    = ram_rd_en_q;
   assign RamAddress = ram_addr_q;
   assign RamWrData  = ram_wdata_q;
   assign Busy       = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a grant/read-data scoreboard for ram_arbiter.
module tb_ram_arbiter;
   localparam int AW = 4;
   localparam int MW = 16;
   logic          clk = 1'b0;
   logic          rst, req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [MW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_wr_en, ram_rd_en, busy;
   logic [MW-1:0] rdata, ram_wdata, ram_rd_data;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] mem [16];
   int            checks = 0, errors = 0, cyc = 0, exp_last = 1;
   typedef struct {int id; logic we; logic [AW-1:0] addr; logic [MW-1:0] data; int cyc;} exp_t;
   exp_t gq[$], rq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_arbiter #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) dut (
      .Clk(clk), .Rst(rst), .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
      .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
      .Gnt0(gnt0), .Gnt1(gnt1), .RValid0(rvalid0), .RValid1(rvalid1), .RData(rdata),
      .RamWrEn(ram_wr_en), .RamRdEn(ram_rd_en), .RamAddress(ram_addr), .RamWrData(ram_wdata),
      .RamRdData(ram_rd_data), .Busy(busy)
   );

   // Simple synchronous RAM: read data valid the cycle after RdEn
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr] <= ram_wdata;
      if (ram_rd_en) ram_rd_data <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      chk("wr_rd_excl", {31'b0, ram_wr_en & ram_rd_en}, 0);
      chk("en_outside_access", {31'b0, (ram_wr_en | ram_rd_en) & ~(gnt0 | gnt1)}, 0);
      chk("gnt_excl", {31'b0, gnt0 & gnt1}, 0);
      chk("rvalid_excl", {31'b0, rvalid0 & rvalid1}, 0);
      if (gnt0 | gnt1) begin
         if (gq.size() == 0) chk("unexpected_gnt", {30'b0, gnt1, gnt0}, 0);
         else begin
            e = gq.pop_front();
            chk("gnt_id", {31'b0, gnt1}, e.id);
            chk("gnt_cycle", cyc, e.cyc);
            chk("ram_wren", {31'b0, ram_wr_en}, {31'b0, e.we});
            chk("ram_rden", {31'b0, ram_rd_en}, {31'b0, ~e.we});
            chk("ram_addr", {28'b0, ram_addr}, {28'b0, e.addr});
            if (e.we) chk("ram_wdata", {16'b0, ram_wdata}, {16'b0, e.data});
         end
      end
      if (rvalid0 | rvalid1) begin
         if (rq.size() == 0) chk("unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 0);
         else begin
            e = rq.pop_front();
            chk("rvalid_id", {31'b0, rvalid1}, e.id);
            chk("rvalid_cycle", cyc, e.cyc);
            chk("rdata", {16'b0, rdata}, {16'b0, e.data});
         end
      end
   end

   // Called at a negedge with the FSM idle; returns at the first negedge the FSM is idle again
   task automatic access(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [MW-1:0] d, input logic [MW-1:0] exp_rd);
      exp_t e;
      e.id = id; e.we = we; e.addr = a; e.data = d; e.cyc = cyc + 1;
      gq.push_back(e);
      exp_last = id;
      if (!we) begin
         e.data = exp_rd; e.cyc = cyc + 3;
         rq.push_back(e);
      end
      if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
      else begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
      @(negedge clk);
      req0 = 0; req1 = 0;
      addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d; we0 = ~we; we1 = ~we;
      @(negedge clk);
      if (!we) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      int   win, c0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst = 1; req0 = 1; we0 = 1; addr0 = 1; wdata0 = 5;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_ctrl", {25'b0, gnt0, gnt1, rvalid0, rvalid1, ram_wr_en, ram_rd_en, busy}, 0);
         chk("rst_addr", {28'b0, ram_addr}, 0);
         chk("rst_wdata", {16'b0, ram_wdata}, 0);
         chk("rst_rdata", {16'b0, rdata}, 0);
      end
      rst = 0; req0 = 0; exp_last = 1;
      @(negedge clk);
      access(0, 1, 2, 10, 0);
      access(0, 0, 2, 0, 10);
      access(1, 1, 3, 25, 0);
      chk("rdata_hold", {16'b0, rdata}, 10);
      access(0, 0, 3, 0, 25);
      chk("busy_idle", {31'b0, busy}, 0);
      // Contention: both requesters hold writes for six grants
      c0 = cyc;
      req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'h0a0a;
      req1 = 1; we1 = 1; addr1 = 4; wdata1 = 16'hb0b0;
      for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         win = (exp_last == 1) ? 0 : 1;
`else
         win = 0;
`endif
         e.id = win; e.we = 1; e.addr = win ? 4'd4 : 4'd3;
         e.data = win ? 16'hb0b0 : 16'h0a0a; e.cyc = c0 + 1 + 2 * k;
         gq.push_back(e);
         exp_last = win;
      end
      repeat (11) @(posedge clk);
      @(negedge clk);
      req0 = 0; req1 = 0;
      @(negedge clk);
      access(1, 1, 3, 25, 0);
      // Reset during RDWAIT aborts the read
      e.id = 1; e.we = 0; e.addr = 3; e.data = 0; e.cyc = cyc + 1;
      gq.push_back(e);
      req1 = 1; we1 = 0; addr1 = 3;
      @(negedge clk);
      req1 = 0;
      @(negedge clk);
      chk("busy_rdwait", {31'b0, busy}, 1);
      rst = 1;
      @(negedge clk);
      chk("abort_ctrl", {27'b0, rvalid0, rvalid1, ram_wr_en, ram_rd_en, busy}, 0);
      chk("abort_rdata", {16'b0, rdata}, 0);
      rst = 0; exp_last = 1;
      @(negedge clk);
      chk("abort_no_rvalid", {30'b0, rvalid0, rvalid1}, 0);
      access(1, 0, 3, 0, 25);
      access(0, 1, 5, 16'h1234, 0);
      chk("rdata_hold2", {16'b0, rdata}, 25);
      repeat (3) @(negedge clk);
      chk("gnt_queue_empty", gq.size(), 0);
      chk("rvalid_queue_empty", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
